slurm32_cpu_hazard_pipeline: RTL
================================

Name: slurm32_cpu_hazard_pipeline

Overview:
- Consumer end of the SLURM32 hazard interface.
- Takes the p0 hazard export (destination register and flag-write indication) and carries it through pipeline stages 1-3. Feeds these back as hazard_reg1..3 and modifies_flags1..3.
- Acts on the returned hazard_1..3 indications: stalls p0 and injects bubbles into stage 1.
- Also handles branch flush, memory freeze, a stall watchdog and a stall-cycle performance counter.

Parameters:
- REGISTER_BITS, 8, width of register select / hazard register fields; value 0 means "no hazard" (r0).
- STALL_CNT_BITS, 16, width of saturating stall-cycle counter.
- MAX_STALL, 3, longest legal consecutive hazard stall, in cycles.

Ports:
- CLK  in  1  clock.
- RSTb  in  1  asynchronous active-low reset.
- hazard_reg0  in  REGISTER_BITS  register p0 will write (from hazard detector).
- modifies_flags0  in  1  p0 writes flags.
- valid0  in  1  p0 holds a real instruction.
- hazard_1, hazard_2, hazard_3  in  1 each  p0 depends on stage 1/2/3 result.
- flush  in  1  branch taken, resolved in stage 2.
- mem_stall  in  1  memory not ready; freeze whole pipeline.
- hazard_reg1, hazard_reg2, hazard_reg3  out  REGISTER_BITS  pipelined hazard registers.
- modifies_flags1, modifies_flags2, modifies_flags3  out  1 each  pipelined flag hazards.
- stall_p0  out  1  hold fetch/p0 this cycle (combinational).
- bubble_p1  out  1  stage 1 receives a NOP this cycle (combinational).
- pipe_state  out  2  FSM state: 0 RUN, 1 STALL, 2 FROZEN.
- stall_cycles  out  STALL_CNT_BITS  saturating count of hazard-stall cycles.
- hazard_error  out  1  sticky watchdog flag.

Behaviour:
- Reset (RSTb low, async): all hazard_reg1..3 = 0, modifies_flags1..3 = 0, pipe_state = RUN, stall_cycles = 0, hazard_error = 0, internal stall run-length = 0.
- Combinational:
  - haz_any = hazard_1 | hazard_2 | hazard_3.
  - stall_p0 = mem_stall | (haz_any & ~flush & valid0).
  - bubble_p1 = ~mem_stall & (flush | ~valid0 | haz_any).
- Priority per rising edge: mem_stall > flush > hazard > normal.
- mem_stall = 1: every stage register holds; counters hold; pipe_state <= FROZEN. flush is ignored while mem_stall is high; the source must hold flush until mem_stall drops.
- flush (mem_stall = 0):
  - stage3 <= stage2 (the branch itself);
  - stage2 <= 0 / 0;
  - stage1 <= 0 / 0;
  - pipe_state <= RUN; stall run-length cleared.
  - A hazard in the same cycle is discarded, because p0 is squashed.
- Hazard (haz_any & valid0, no flush, no mem_stall):
  - stage3 <= stage2, stage2 <= stage1;
  - stage1 <= 0 / 0 (bubble);
  - pipe_state <= STALL;
  - stall_cycles += 1, saturating at all-ones;
  - run-length += 1.
- Normal: stage3 <= stage2, stage2 <= stage1. stage1 <= hazard_reg0 / modifies_flags0 if valid0, else 0 / 0. pipe_state <= RUN; run-length cleared.
- A "stage" is the pair (hazard_reg, modifies_flags); the two fields always move together.
- Leaving FROZEN: the next state follows the rules above for that cycle's inputs.
- Watchdog: if the run-length would exceed MAX_STALL, hazard_error <= 1. It stays set until reset. Pipeline behaviour is unchanged.
- Run-length counter saturates at MAX_STALL+1.
- Hazard dependence draining: a hazard_1 stall lasts at most 3 cycles, because bubbles push the producer to stage 3 and then out.
- hazard_reg0 = 0 with modifies_flags0 = 0 is a legal non-hazard instruction and is pipelined as zeros.

Test Plan:
- Reset mid-stream: stages hold 0x05/0x07/0x09, assert RSTb low asynchronously -> all outputs 0 and pipe_state = RUN before the next CLK edge.
- Normal flow: valid0 = 1 with hazard_reg0 = 0x03, 0x04, 0x05 on consecutive cycles, no hazards -> hazard_reg3 = 0x03 on cycle 3, bubble_p1 = 0 throughout.
- Hazard on stage 1:
  - Setup: hazard_reg1 = 0x03; the bench drives hazard_1 for 1 cycle, then hazard_2, then hazard_3.
  - Per cycle: stall_p0 = 1 and bubble_p1 = 1.
  - Pipeline: 0x03 walks stage 2 -> 3 with zeros behind it.
  - Counters: stall_cycles = 3, hazard_error = 0.
- Flush with a concurrent hazard: stages 0x0A/0x0B/0x0C with flush = 1 and hazard_1 = 1 -> next stages 0/0/0x0B, stall_p0 = 0, stall_cycles unchanged.
- Memory freeze: mem_stall = 1 for 4 cycles with hazard_2 = 1 -> stages and stall_cycles unchanged, pipe_state = FROZEN; on release the hazard stall proceeds normally.
- Watchdog: hold hazard_3 = 1 for 4 consecutive cycles -> hazard_error rises after the 4th edge and stays set. Drive stall_cycles to 0xFFFF -> it stays at 0xFFFF.

Source files
------------

// File: rtl/slurm32_cpu_hazard_pipeline.sv
// SLURM32 hazard pipeline: carries the p0 hazard export through stages 1-3,
// stalls p0 / bubbles stage 1 on returned hazards, and tracks stall statistics.
module slurm32_cpu_hazard_pipeline #(
    parameter int unsigned REGISTER_BITS  = 8,
    parameter int unsigned STALL_CNT_BITS = 16,
    parameter int unsigned MAX_STALL      = 3
) (
    input  logic                      CLK,
    input  logic                      RSTb,
    input  logic [REGISTER_BITS-1:0]  hazard_reg0,
    input  logic                      modifies_flags0,
    input  logic                      valid0,
    input  logic                      hazard_1,
    input  logic                      hazard_2,
    input  logic                      hazard_3,
    input  logic                      flush,
    input  logic                      mem_stall,
    output logic [REGISTER_BITS-1:0]  hazard_reg1,
    output logic [REGISTER_BITS-1:0]  hazard_reg2,
    output logic [REGISTER_BITS-1:0]  hazard_reg3,
    output logic                      modifies_flags1,
    output logic                      modifies_flags2,
    output logic                      modifies_flags3,
    output logic                      stall_p0,
    output logic                      bubble_p1,
    output logic [1:0]                pipe_state,
    output logic [STALL_CNT_BITS-1:0] stall_cycles,
    output logic                      hazard_error
);

    localparam int unsigned RUN_BITS   = $clog2(MAX_STALL + 2);
    localparam logic [1:0]  ST_RUN     = 2'd0;
    localparam logic [1:0]  ST_STALL   = 2'd1;
    localparam logic [1:0]  ST_FROZEN  = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      w_haz_any;
    logic                      w_hazard;
    logic [REGISTER_BITS-1:0]  r_reg1, r_reg2, r_reg3;
    logic                      r_mf1, r_mf2, r_mf3;
    logic [STALL_CNT_BITS-1:0] r_stall_cnt;
    logic [STALL_CNT_BITS-1:0] w_stall_cnt_inc;
    logic [RUN_BITS-1:0]       r_run;
    logic [RUN_BITS-1:0]       w_run_inc;
    logic                      r_err;

    assign w_haz_any = hazard_1 | hazard_2 | hazard_3;
    assign w_hazard  = w_haz_any & valid0;

    // Both counters saturate rather than wrap.
    assign w_stall_cnt_inc = (r_stall_cnt == '1) ? r_stall_cnt
                                                 : r_stall_cnt + STALL_CNT_BITS'(1);
    assign w_run_inc = (r_run == RUN_BITS'(MAX_STALL + 1)) ? r_run
                                                           : r_run + RUN_BITS'(1);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (mem_stall) begin
            w_state_nxt = ST_FROZEN;
        end else if (flush) begin
            w_state_nxt = ST_RUN;
        end else if (w_hazard) begin
            w_state_nxt = ST_STALL;
        end
    end

    // Stall/bubble depend only on this cycle's inputs, not on the state.
    always_comb begin
        stall_p0  = 1'b0;
        bubble_p1 = 1'b0;
        stall_p0  = mem_stall | (w_haz_any & ~flush & valid0);
        bubble_p1 = ~mem_stall & (flush | ~valid0 | w_haz_any);
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_reg3      <= '0;
            r_mf1       <= 1'b0;
            r_mf2       <= 1'b0;
            r_mf3       <= 1'b0;
            r_stall_cnt <= '0;
            r_run       <= '0;
            r_err       <= 1'b0;
        end else if (!mem_stall) begin
            r_reg3 <= r_reg2;
            r_mf3  <= r_mf2;
            if (flush) begin
                // p0 and stage 1 are squashed; the branch in stage 2 retires.
                r_reg2 <= '0;
                r_mf2  <= 1'b0;
                r_reg1 <= '0;
                r_mf1  <= 1'b0;
                r_run  <= '0;
            end else if (w_hazard) begin
                r_reg2      <= r_reg1;
                r_mf2       <= r_mf1;
                r_reg1      <= '0;
                r_mf1       <= 1'b0;
                r_stall_cnt <= w_stall_cnt_inc;
                r_run       <= w_run_inc;
                if (32'(w_run_inc) > MAX_STALL) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_reg2 <= r_reg1;
                r_mf2  <= r_mf1;
                r_reg1 <= valid0 ? hazard_reg0 : '0;
                r_mf1  <= valid0 & modifies_flags0;
                r_run  <= '0;
            end
        end
    end

    assign hazard_reg1     = r_reg1;
    assign hazard_reg2     = r_reg2;
    assign hazard_reg3     = r_reg3;
    assign modifies_flags1 = r_mf1;
    assign modifies_flags2 = r_mf2;
    assign modifies_flags3 = r_mf3;
    assign pipe_state      = r_state;
    assign stall_cycles    = r_stall_cnt;
    assign hazard_error    = r_err;

endmodule
